// File: rtl/gates_test_reg.sv
// rtl/gates_test_reg.sv - registered bank of 4-state gate reference results
//
// Purpose:
//   Golden reference for gate-netlist checking. It computes NOT/BUF of src1
//   and src2. It also computes the 2-, 3- and 4-input AND/OR/XOR/NAND/NOR/XNOR
//   of src1..src4, using gate-primitive X/Z semantics. Every result is
//   registered once, so each output shows the inputs sampled at the previous
//   rising clk.
//
// Ports:
//   clk                      rising-edge clock
//   rst_n                    asynchronous active-low reset, clears all outputs
//   src1..src4   [SIZE-1:0]  operands A..D (bitwise, lanes independent)
//   out_not/out_buf          ~src1 / src1
//   out_not2/out_buf2        ~src2 / src2
//   out_{and,or,xor,nand,nor,xnor}        2-input gates of src1,src2
//   out_{and,or,xor,nand,nor,xnor}3       3-input gates of src1..src3
//   out_{and,or,xor,nand,nor,xnor}4       4-input gates of src1..src4

module gates_test_reg #(
    parameter int SIZE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] src1,
    input  logic [SIZE-1:0] src2,
    input  logic [SIZE-1:0] src3,
    input  logic [SIZE-1:0] src4,
    output logic [SIZE-1:0] out_not,
    output logic [SIZE-1:0] out_buf,
    output logic [SIZE-1:0] out_not2,
    output logic [SIZE-1:0] out_buf2,
    output logic [SIZE-1:0] out_and,
    output logic [SIZE-1:0] out_or,
    output logic [SIZE-1:0] out_xor,
    output logic [SIZE-1:0] out_nand,
    output logic [SIZE-1:0] out_nor,
    output logic [SIZE-1:0] out_xnor,
    output logic [SIZE-1:0] out_and3,
    output logic [SIZE-1:0] out_or3,
    output logic [SIZE-1:0] out_xor3,
    output logic [SIZE-1:0] out_nand3,
    output logic [SIZE-1:0] out_nor3,
    output logic [SIZE-1:0] out_xnor3,
    output logic [SIZE-1:0] out_and4,
    output logic [SIZE-1:0] out_or4,
    output logic [SIZE-1:0] out_xor4,
    output logic [SIZE-1:0] out_nand4,
    output logic [SIZE-1:0] out_nor4,
    output logic [SIZE-1:0] out_xnor4
);

    logic [SIZE-1:0] not_d,  not_q,  buf_d,  buf_q;
    logic [SIZE-1:0] not2_d, not2_q, buf2_d, buf2_q;
    logic [SIZE-1:0] and_d,  and_q,  or_d,   or_q,   xor_d,  xor_q;
    logic [SIZE-1:0] nand_d, nand_q, nor_d,  nor_q,  xnor_d, xnor_q;
    logic [SIZE-1:0] and3_d,  and3_q,  or3_d,  or3_q,  xor3_d,  xor3_q;
    logic [SIZE-1:0] nand3_d, nand3_q, nor3_d, nor3_q, xnor3_d, xnor3_q;
    logic [SIZE-1:0] and4_d,  and4_q,  or4_d,  or4_q,  xor4_d,  xor4_q;
    logic [SIZE-1:0] nand4_d, nand4_q, nor4_d, nor4_q, xnor4_d, xnor4_q;

    // The bitwise operators already follow gate-primitive rules lane by lane:
    // a controlling 0 (AND) or 1 (OR) wins over X, XOR of any X is X, and a Z
    // operand is read as X. The inverting gates are plain inversions, so an X
    // result stays X.
    always_comb begin
        not_d   = ~src1;
        // A bare copy would let a Z on src1 reach the flop. The double
        // inversion turns Z into X and leaves 0/1/X untouched.
        buf_d   = ~(~src1);
        not2_d  = ~src2;
        buf2_d  = ~(~src2);

        and_d   = src1 & src2;
        or_d    = src1 | src2;
        xor_d   = src1 ^ src2;
        nand_d  = ~and_d;
        nor_d   = ~or_d;
        xnor_d  = ~xor_d;

        and3_d  = src1 & src2 & src3;
        or3_d   = src1 | src2 | src3;
        xor3_d  = src1 ^ src2 ^ src3;
        nand3_d = ~and3_d;
        nor3_d  = ~or3_d;
        xnor3_d = ~xor3_d;

        and4_d  = src1 & src2 & src3 & src4;
        or4_d   = src1 | src2 | src3 | src4;
        xor4_d  = src1 ^ src2 ^ src3 ^ src4;
        nand4_d = ~and4_d;
        nor4_d  = ~or4_d;
        xnor4_d = ~xor4_d;
    end

    // Plain data flops: an X result is captured and held as X, never forced
    // to 0/1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            not_q   <= '0;
            buf_q   <= '0;
            not2_q  <= '0;
            buf2_q  <= '0;
            and_q   <= '0;
            or_q    <= '0;
            xor_q   <= '0;
            nand_q  <= '0;
            nor_q   <= '0;
            xnor_q  <= '0;
            and3_q  <= '0;
            or3_q   <= '0;
            xor3_q  <= '0;
            nand3_q <= '0;
            nor3_q  <= '0;
            xnor3_q <= '0;
            and4_q  <= '0;
            or4_q   <= '0;
            xor4_q  <= '0;
            nand4_q <= '0;
            nor4_q  <= '0;
            xnor4_q <= '0;
        end else begin
            not_q   <= not_d;
            buf_q   <= buf_d;
            not2_q  <= not2_d;
            buf2_q  <= buf2_d;
            and_q   <= and_d;
            or_q    <= or_d;
            xor_q   <= xor_d;
            nand_q  <= nand_d;
            nor_q   <= nor_d;
            xnor_q  <= xnor_d;
            and3_q  <= and3_d;
            or3_q   <= or3_d;
            xor3_q  <= xor3_d;
            nand3_q <= nand3_d;
            nor3_q  <= nor3_d;
            xnor3_q <= xnor3_d;
            and4_q  <= and4_d;
            or4_q   <= or4_d;
            xor4_q  <= xor4_d;
            nand4_q <= nand4_d;
            nor4_q  <= nor4_d;
            xnor4_q <= xnor4_d;
        end
    end

    assign out_not   = not_q;
    assign out_buf   = buf_q;
    assign out_not2  = not2_q;
    assign out_buf2  = buf2_q;
    assign out_and   = and_q;
    assign out_or    = or_q;
    assign out_xor   = xor_q;
    assign out_nand  = nand_q;
    assign out_nor   = nor_q;
    assign out_xnor  = xnor_q;
    assign out_and3  = and3_q;
    assign out_or3   = or3_q;
    assign out_xor3  = xor3_q;
    assign out_nand3 = nand3_q;
    assign out_nor3  = nor3_q;
    assign out_xnor3 = xnor3_q;
    assign out_and4  = and4_q;
    assign out_or4   = or4_q;
    assign out_xor4  = xor4_q;
    assign out_nand4 = nand4_q;
    assign out_nor4  = nor4_q;
    assign out_xnor4 = xnor4_q;

endmodule

// File: tb/tb_gates_test_reg.sv
// tb/tb_gates_test_reg.sv - self-checking bench for gates_test_reg
module tb_gates_test_reg;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] s1, s2, s3, s4;

    logic [W-1:0] o_not, o_buf, o_not2, o_buf2;
    logic [W-1:0] o_and, o_or, o_xor, o_nand, o_nor, o_xnor;
    logic [W-1:0] o_and3, o_or3, o_xor3, o_nand3, o_nor3, o_xnor3;
    logic [W-1:0] o_and4, o_or4, o_xor4, o_nand4, o_nor4, o_xnor4;

    int errors = 0;
    int checks = 0;

    string names [22] = '{"not", "buf", "not2", "buf2",
                          "and", "or", "xor", "nand", "nor", "xnor",
                          "and3", "or3", "xor3", "nand3", "nor3", "xnor3",
                          "and4", "or4", "xor4", "nand4", "nor4", "xnor4"};

    gates_test_reg #(.SIZE(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .src1(s1), .src2(s2), .src3(s3), .src4(s4),
        .out_not(o_not), .out_buf(o_buf), .out_not2(o_not2), .out_buf2(o_buf2),
        .out_and(o_and), .out_or(o_or), .out_xor(o_xor),
        .out_nand(o_nand), .out_nor(o_nor), .out_xnor(o_xnor),
        .out_and3(o_and3), .out_or3(o_or3), .out_xor3(o_xor3),
        .out_nand3(o_nand3), .out_nor3(o_nor3), .out_xnor3(o_xnor3),
        .out_and4(o_and4), .out_or4(o_or4), .out_xor4(o_xor4),
        .out_nand4(o_nand4), .out_nor4(o_nor4), .out_xnor4(o_xnor4)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] dut_out(input int k);
        case (k)
            0:  return o_not;   1:  return o_buf;   2:  return o_not2;  3:  return o_buf2;
            4:  return o_and;   5:  return o_or;    6:  return o_xor;
            7:  return o_nand;  8:  return o_nor;   9:  return o_xnor;
            10: return o_and3;  11: return o_or3;   12: return o_xor3;
            13: return o_nand3; 14: return o_nor3;  15: return o_xnor3;
            16: return o_and4;  17: return o_or4;   18: return o_xor4;
            19: return o_nand4; 20: return o_nor4;  default: return o_xnor4;
        endcase
    endfunction

    // Reference: per lane, classify each used input as 0, 1 or unknown (X/Z)
    // and apply the gate rules by counting.
    function automatic logic [W-1:0] model(input int k, input logic [W-1:0] a, b, c, d);
        logic [W-1:0] r;
        logic         v [4];
        logic         u, g;
        int           n, op, zeros, ones, unk;
        r = '0;
        for (int l = 0; l < W; l++) begin
            v[0] = a[l]; v[1] = b[l]; v[2] = c[l]; v[3] = d[l];
            if (k < 4) begin
                u = v[k / 2];
                if (u === 1'b0 || u === 1'b1) g = (k % 2 == 0) ? ~u : u;
                else                          g = 1'bx;
            end else begin
                n = 2 + (k - 4) / 6;
                op = (k - 4) % 6;
                zeros = 0; ones = 0; unk = 0;
                for (int i = 0; i < n; i++) begin
                    if (v[i] === 1'b0)      zeros++;
                    else if (v[i] === 1'b1) ones++;
                    else                    unk++;
                end
                case (op % 3)
                    0:       g = (zeros > 0) ? 1'b0 : (unk > 0) ? 1'bx : 1'b1;
                    1:       g = (ones > 0)  ? 1'b1 : (unk > 0) ? 1'bx : 1'b0;
                    default: g = (unk > 0)   ? 1'bx : ((ones % 2) == 1);
                endcase
                if (op >= 3 && (g === 1'b0 || g === 1'b1)) g = ~g;
            end
            r[l] = g;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand4();
        logic [W-1:0] r;
        for (int l = 0; l < W; l++) begin
            case ($urandom_range(0, 5))
                0, 1:    r[l] = 1'b0;
                2, 3:    r[l] = 1'b1;
                4:       r[l] = 1'bx;
                default: r[l] = 1'bz;
            endcase
        end
        return r;
    endfunction

    task automatic test_reset();
        bit exp_bits [22] = '{0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1,
                              0, 1, 1, 1, 0, 0};
        logic [W-1:0] got, exp;
        @(negedge clk);
        s1 = 'x; s2 = 'x; s3 = 'x; s4 = 'x;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 22; k++) begin
            checks++;
            got = dut_out(k);
            if (got !== '0) begin
                errors++;
                $display("FAIL reset_%s: got %b expected %b", names[k], got, {W{1'b0}});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        s1 = '1; s2 = '0; s3 = '1; s4 = '1;
        @(posedge clk); #1;
        for (int k = 0; k < 22; k++) begin
            checks++;
            got = dut_out(k);
            exp = {W{exp_bits[k]}};
            if (got !== exp) begin
                errors++;
                $display("FAIL first_%s: got %b expected %b", names[k], got, exp);
            end
        end
    endtask

    task automatic apply_and_check(input string tag, input logic [W-1:0] a, b, c, d);
        logic [W-1:0] got, exp;
        @(negedge clk);
        s1 = a; s2 = b; s3 = c; s4 = d;
        @(posedge clk); #1;
        for (int k = 0; k < 22; k++) begin
            checks++;
            got = dut_out(k);
            exp = model(k, a, b, c, d);
            if (got !== exp) begin
                errors++;
                $display("FAIL %s_%s: got %b expected %b (src %b %b %b %b)",
                         tag, names[k], got, exp, a, b, c, d);
            end
        end
    endtask

    task automatic test_sweep();
        logic vals [4];
        vals[0] = 1'b0; vals[1] = 1'b1; vals[2] = 1'bx; vals[3] = 1'bz;
        for (int i = 0; i < 64; i++)
            apply_and_check("sweep", {W{vals[i % 4]}}, {W{vals[(i / 4) % 4]}},
                            {W{vals[i / 16]}}, '0);
    endtask

    task automatic test_dominance();
        apply_and_check("dom0x", '0, 'x, '0, '0);
        apply_and_check("dom1z", '1, 'z, '0, '0);
    endtask

    task automatic test_float();
        apply_and_check("float1", '1, '1, '1, 'z);
        apply_and_check("float0", '0, '1, '1, 'z);
    endtask

    task automatic test_latency();
        logic [W-1:0] a, b, got, exp;
        a = $urandom; b = ~a;
        apply_and_check("lat_a", a, b, a, b);
        @(negedge clk);
        s1 = b; s2 = a; s3 = b; s4 = a;
        #1;
        for (int k = 0; k < 22; k++) begin
            checks++;
            got = dut_out(k);
            exp = model(k, a, b, a, b);
            if (got !== exp) begin
                errors++;
                $display("FAIL hold_%s: got %b expected %b", names[k], got, exp);
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 22; k++) begin
            checks++;
            got = dut_out(k);
            exp = model(k, b, a, b, a);
            if (got !== exp) begin
                errors++;
                $display("FAIL update_%s: got %b expected %b", names[k], got, exp);
            end
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 22; k++) begin
            checks++;
            got = dut_out(k);
            if (got !== '0) begin
                errors++;
                $display("FAIL midrst_%s: got %b expected %b", names[k], got, {W{1'b0}});
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (o_or !== '0) begin
            errors++;
            $display("FAIL rst_release_no_edge: got %b expected %b", o_or, {W{1'b0}});
        end
        apply_and_check("post_rst", a, a, b, b);
    endtask

    task automatic test_size4();
        apply_and_check("size4", 4'b01xz, 4'b1100, '0, '0);
        checks++;
        if (o_and !== 4'b0100) begin
            errors++;
            $display("FAIL size4_and_const: got %b expected %b", o_and, 4'b0100);
        end
        checks++;
        if (o_buf2 !== 4'b1100) begin
            errors++;
            $display("FAIL size4_buf2_const: got %b expected %b", o_buf2, 4'b1100);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 150; i++)
            apply_and_check("rand4", rand4(), rand4(), rand4(), rand4());
        for (int i = 0; i < 150; i++)
            apply_and_check("rand2", W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    initial begin
        s1 = '0; s2 = '0; s3 = '0; s4 = '0;
        test_reset();
        test_sweep();
        test_dominance();
        test_float();
        test_latency();
        test_size4();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
